// File: rtl/debug_apb_arbiter.sv
// Two-port APB arbiter that serialises debug requesters onto one CPU-access completer.
// Optional macro DEBUG_ARB_ROUND_ROBIN_EN selects round-robin tie-break (default: port 0 priority).
module debug_apb_arbiter (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       S0_PSEL,
  input  logic       S0_PENABLE,
  input  logic       S0_PWRITE,
  input  logic [4:0] S0_PADDR,
  input  logic [7:0] S0_PWDATA,
  output logic [7:0] S0_PRDATA,
  output logic       S0_PREADY,
  input  logic       S1_PSEL,
  input  logic       S1_PENABLE,
  input  logic       S1_PWRITE,
  input  logic [4:0] S1_PADDR,
  input  logic [7:0] S1_PWDATA,
  output logic [7:0] S1_PRDATA,
  output logic       S1_PREADY,
  output logic       M_PSEL,
  output logic       M_PENABLE,
  output logic       M_PWRITE,
  output logic [4:0] M_PADDR,
  output logic [7:0] M_PWDATA,
  input  logic [7:0] M_PRDATA,
  input  logic       M_PREADY,
  output logic [1:0] GRANT
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic [7:0] rdata_q, rdata_d;
  logic       tie_to_1;
  logic       pick_1;

  // Only PSEL counts as a request; upstream PENABLE has no role here.
  logic unused_penable;
  assign unused_penable = S0_PENABLE ^ S1_PENABLE;

`ifdef DEBUG_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign tie_to_1 = ~last_q;
`else
  assign tie_to_1 = 1'b0;
`endif

  assign pick_1 = S1_PSEL & (~S0_PSEL | tie_to_1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
`ifdef DEBUG_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (S0_PSEL || S1_PSEL) begin
          grant_d = pick_1 ? 2'b10 : 2'b01;
          addr_d  = pick_1 ? S1_PADDR  : S0_PADDR;
          wdata_d = pick_1 ? S1_PWDATA : S0_PWDATA;
          write_d = pick_1 ? S1_PWRITE : S0_PWRITE;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (M_PREADY) begin
          rdata_d = M_PRDATA;
          state_d = RESP;
        end
      end
      RESP: begin
`ifdef DEBUG_ARB_ROUND_ROBIN_EN
        last_d  = grant_q[1];
`endif
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      addr_q  <= 5'h00;
      wdata_q <= 8'h00;
      write_q <= 1'b0;
      rdata_q <= 8'h00;
`ifdef DEBUG_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
`ifdef DEBUG_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Every output comes from state or holding registers, never straight from an input.
  assign M_PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign M_PENABLE = (state_q == ACCESS);
  assign M_PWRITE  = write_q;
  assign M_PADDR   = addr_q;
  assign M_PWDATA  = wdata_q;
  assign GRANT     = grant_q;
  assign S0_PREADY = (state_q == RESP) && grant_q[0];
  assign S1_PREADY = (state_q == RESP) && grant_q[1];
  assign S0_PRDATA = S0_PREADY ? rdata_q : 8'h00;
  assign S1_PRDATA = S1_PREADY ? rdata_q : 8'h00;

endmodule
